// File: rtl/mac_4bit_seq_if.sv
// Handshake and result bundle between a beat source and the 4x4 MAC sequencer.
// The source owns start/len/A/B/in_valid; the MAC owns in_ready/busy/done/acc_out/ovf.
interface mac_4bit_seq_if #(
  parameter int LEN_W = 5,
  parameter int ACC_W = 12
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [3:0]       A;
  logic [3:0]       B;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output start, len, A, B, in_valid,
    input  in_ready, busy, done, acc_out, ovf
  );

  modport slave (
    input  start, len, A, B, in_valid,
    output in_ready, busy, done, acc_out, ovf
  );
endinterface

// File: rtl/mac_4bit_seq.sv
// Sequential saturating multiply-accumulate over a run of len 4x4 beats; one beat per cycle,
// done pulses the cycle after the last accepted beat; in_ready only in RUN, bubbles stall the run.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module mult_4bit_structural (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] pp [4];
  logic [3:0] r  [4];
  logic [4:0] c  [1:3];
  logic [3:0] s  [1:3];

  genvar i, j;
  for (i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = a & {4{b[i]}};
  end

  // r[i] carries the not-yet-final upper bits of the running sum into row i+1
  assign r[0] = {1'b0, pp[0][3:1]};

  for (i = 1; i < 4; i++) begin : g_row
    assign c[i][0] = 1'b0;
    for (j = 0; j < 4; j++) begin : g_col
      full_adder u_fa (
        .a    (r[i-1][j]),
        .b    (pp[i][j]),
        .cin  (c[i][j]),
        .sum  (s[i][j]),
        .cout (c[i][j+1])
      );
    end
    assign r[i] = {c[i][4], s[i][3:1]};
  end

  assign p = {r[3], s[3][0], s[2][0], s[1][0], pp[0][0]};
endmodule

module mac_4bit_seq #(
  parameter int LEN_W = 5,
  parameter int ACC_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_4bit_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [7:0]       prod;
  logic [ACC_W:0]   sum;
  logic             in_ready, busy, done;

  mult_4bit_structural u_mult (
    .a (bus.A),
    .b (bus.B),
    .p (prod)
  );

  // one spare bit catches the carry-out that triggers saturation
  assign sum = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.len != '0) begin
            cnt_nxt   = bus.len;
            state_nxt = RUN;
          end else begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (bus.in_valid) begin
          if (sum[ACC_W]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum[ACC_W-1:0];
          end
          cnt_nxt = cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.acc_out  = acc;
  assign bus.ovf      = ovf;
endmodule
